// File: rtl/switch_debouncer.sv
// switch_debouncer
// Brings a bus of asynchronous switch levels into the clk_i domain and
// filters contact bounce for the whole bus with one shared settle counter.
// sw_o only ever takes a value that has been sampled DEBOUNCE_CYCLES times in
// a row, so every bit of the bus changes together. upd_o pulses for one
// cycle on each commit, and busy_o is high while a candidate is settling.
module switch_debouncer #(
  parameter int WIDTH           = 11,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] sw_o,
  output logic             upd_o,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  // Synchroniser chain; index SYNC_STAGES-1 is the oldest, settled sample.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sw_d;
  logic             upd_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift raw levels through the synchroniser chain.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  // Settle FSM: track the candidate, count agreeing samples, commit or abort.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    sw_d    = sw_o;
    upd_d   = 1'b0;
    case (state_q)
      STABLE: begin
        if (s != sw_o) begin
          cand_d  = s;
          cnt_d   = CNT_ONE;
          state_d = SETTLING;
        end else begin
          cnt_d = '0;
        end
      end
      SETTLING: begin
        if (s == sw_o) begin
          // Bounce fell back to the committed value: abandon the candidate.
          cnt_d   = '0;
          state_d = STABLE;
        end else if (s != cand_q) begin
          // Any bit moved again: restart settling with the new pattern.
          cand_d = s;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          sw_d    = cand_q;
          upd_d   = 1'b1;
          cnt_d   = '0;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Register FSM state, candidate, counter and outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= STABLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      sw_o    <= '0;
      upd_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      sw_o    <= sw_d;
      upd_o   <= upd_d;
    end
  end

  assign busy_o = (state_q == SETTLING);

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with WIDTH=11, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// A run-length reference model predicts sw_o/upd_o/busy_o each cycle; its
// predictions go through a scoreboard queue. Segment tables and hand-written
// sequences add end-of-segment and exact-edge checks.
module tb_switch_debouncer;

  localparam int W  = 11;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset_ni;
  logic [W-1:0] raw_i;
  logic [W-1:0] sw_o;
  logic         upd_o;
  logic         busy_o;

  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH(W),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_i(clk),
    .reset_ni(reset_ni),
    .raw_i(raw_i),
    .sw_o(sw_o),
    .upd_o(upd_o),
    .busy_o(busy_o)
  );

  typedef struct {
    logic [W-1:0] sw;
    logic         upd;
    logic         busy;
  } exp_t;

  typedef struct {
    logic [W-1:0] raw;
    int           hold;
    logic [W-1:0] exp_sw;
    int           exp_upd;
    int           exp_busy;
  } vec_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: s history modelled as a run of identical samples.
  logic [W-1:0] m_sync[SS];
  logic [W-1:0] m_sw;
  logic [W-1:0] m_val;
  int           m_run;

  task automatic check_val(input string name, input logic [W-1:0] act,
                           input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%03h, expected 0x%03h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SS; i++) m_sync[i] = '0;
    m_sw  = '0;
    m_val = '0;
    m_run = 0;
    exp_q.delete();
  endtask

  // One rising edge of the model; r is the raw value sampled at that edge.
  task automatic model_edge(input logic [W-1:0] r);
    logic [W-1:0] s_old;
    logic         commit;
    exp_t         e;
    s_old = m_sync[SS-1];
    if (s_old == m_val) begin
      m_run++;
    end else begin
      m_val = s_old;
      m_run = 1;
    end
    commit = (m_run >= DC) && (m_val != m_sw);
    e.busy = (s_old != m_sw) && !commit;
    e.upd  = commit;
    if (commit) m_sw = s_old;
    e.sw = m_sw;
    for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = r;
    exp_q.push_back(e);
  endtask

  // Drive raw away from the edge, clock once, compare against the scoreboard.
  task automatic tick(input logic [W-1:0] r);
    exp_t e;
    raw_i = r;
    @(posedge clk);
    model_edge(r);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = exp_q.pop_front();
      check_val("sw_o", sw_o, e.sw);
      check_val("upd_o", {10'b0, upd_o}, {10'b0, e.upd});
      check_val("busy_o", {10'b0, busy_o}, {10'b0, e.busy});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000 ns");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[11];
    int   upd_cnt;
    int   busy_cnt;

    vecs[0]  = '{raw: 11'h000, hold: 20, exp_sw: 11'h000, exp_upd: 0, exp_busy: 0};
    vecs[1]  = '{raw: 11'h0A5, hold: 10, exp_sw: 11'h0A5, exp_upd: 1, exp_busy: 3};
    vecs[2]  = '{raw: 11'h0A4, hold: 2,  exp_sw: 11'h0A5, exp_upd: 0, exp_busy: 0};
    vecs[3]  = '{raw: 11'h0A5, hold: 10, exp_sw: 11'h0A5, exp_upd: 0, exp_busy: 2};
    vecs[4]  = '{raw: 11'h001, hold: 2,  exp_sw: 11'h0A5, exp_upd: 0, exp_busy: 0};
    vecs[5]  = '{raw: 11'h002, hold: 2,  exp_sw: 11'h0A5, exp_upd: 0, exp_busy: 2};
    vecs[6]  = '{raw: 11'h001, hold: 2,  exp_sw: 11'h0A5, exp_upd: 0, exp_busy: 2};
    vecs[7]  = '{raw: 11'h002, hold: 2,  exp_sw: 11'h0A5, exp_upd: 0, exp_busy: 2};
    vecs[8]  = '{raw: 11'h001, hold: 2,  exp_sw: 11'h0A5, exp_upd: 0, exp_busy: 2};
    vecs[9]  = '{raw: 11'h002, hold: 10, exp_sw: 11'h002, exp_upd: 1, exp_busy: 5};
    vecs[10] = '{raw: 11'h3C3, hold: 12, exp_sw: 11'h3C3, exp_upd: 1, exp_busy: 3};

    // Reset with inputs idle.
    reset_ni = 1'b0;
    raw_i    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_sw", sw_o, 11'h000);
    check_val("reset_upd", {10'b0, upd_o}, 11'h000);
    check_val("reset_busy", {10'b0, busy_o}, 11'h000);
    reset_ni = 1'b1;

    // Table-driven segments: idle, clean change, glitch, bounce, second change.
    for (int v = 0; v < 11; v++) begin
      upd_cnt  = 0;
      busy_cnt = 0;
      for (int c = 0; c < vecs[v].hold; c++) begin
        tick(vecs[v].raw);
        if (upd_o) upd_cnt++;
        if (busy_o) busy_cnt++;
      end
      check_val($sformatf("seg%0d_sw", v), sw_o, vecs[v].exp_sw);
      check_int($sformatf("seg%0d_upd_count", v), upd_cnt, vecs[v].exp_upd);
      check_int($sformatf("seg%0d_busy_count", v), busy_cnt, vecs[v].exp_busy);
    end

    // Clean change with exact commit edge: 0x3C3 -> 0x155, upd on edge 6.
    for (int c = 1; c <= 6; c++) begin
      tick(11'h155);
      if (c < 6) begin
        check_val($sformatf("clean_edge%0d_upd", c), {10'b0, upd_o}, 11'h000);
        check_val($sformatf("clean_edge%0d_sw", c), sw_o, 11'h3C3);
      end else begin
        check_val("clean_edge6_upd", {10'b0, upd_o}, 11'h001);
        check_val("clean_edge6_sw", sw_o, 11'h155);
        check_val("clean_edge6_busy", {10'b0, busy_o}, 11'h000);
      end
    end
    tick(11'h155);
    check_val("clean_upd_single", {10'b0, upd_o}, 11'h000);

    // Reset asserted on the second busy cycle of a settle.
    tick(11'h100);
    tick(11'h100);
    tick(11'h100);
    check_val("midrst_busy1", {10'b0, busy_o}, 11'h001);
    tick(11'h100);
    check_val("midrst_busy2", {10'b0, busy_o}, 11'h001);
    reset_ni = 1'b0;
    raw_i    = 11'h7FF;
    #1;
    model_reset();
    check_val("midrst_sw", sw_o, 11'h000);
    check_val("midrst_busy", {10'b0, busy_o}, 11'h000);
    check_val("midrst_upd", {10'b0, upd_o}, 11'h000);
    repeat (2) @(posedge clk);
    #1;
    check_val("midrst_held_sw", sw_o, 11'h000);
    reset_ni = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick(11'h7FF);
      if (c < 6) check_val($sformatf("relrst_edge%0d_upd", c), {10'b0, upd_o}, 11'h000);
    end
    check_val("relrst_sw", sw_o, 11'h7FF);
    check_val("relrst_upd", {10'b0, upd_o}, 11'h001);
    repeat (3) tick(11'h7FF);

    // Input changes on the very edge where the previous value commits.
    for (int c = 1; c <= 5; c++) tick(11'h010);
    tick(11'h020);
    check_val("cedge_first_sw", sw_o, 11'h010);
    check_val("cedge_first_upd", {10'b0, upd_o}, 11'h001);
    for (int c = 2; c <= 5; c++) begin
      tick(11'h020);
      check_val($sformatf("cedge_wait%0d_upd", c), {10'b0, upd_o}, 11'h000);
      check_val($sformatf("cedge_wait%0d_sw", c), sw_o, 11'h010);
    end
    tick(11'h020);
    check_val("cedge_second_sw", sw_o, 11'h020);
    check_val("cedge_second_upd", {10'b0, upd_o}, 11'h001);
    repeat (4) tick(11'h020);
    check_val("final_sw", sw_o, 11'h020);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Input-conditioning stage between the board switches and the ALU/PWM datapath. Synchronises a bus of raw, asynchronous switch levels into the 100 MHz domain, filters contact bounce with a shared settle counter, and presents a glitch-free registered copy plus a one-cycle update strobe. The top level routes `{op_sw, sw2, sw1}` through this block before they reach the ALU mux, so operands and opcode change atomically.

## Interface
- `WIDTH`, 11: number of switch bits conditioned, with `{op_sw[2:0], sw2[3:0], sw1[3:0]}` packed MSB→LSB.
- `SYNC_STAGES`, 2: flip-flop depth of the synchroniser chain; legal range ≥2.
- `DEBOUNCE_CYCLES`, 2_000_000: consecutive identical samples required to accept a new value, which is 20 ms at 100 MHz; legal range ≥2.

- `clk_i`  input  1  system clock (100 MHz from the clocking network).
- `reset_ni`  input  1  asynchronous, active-low reset.
- `raw_i`  input  WIDTH  raw switch levels, asynchronous to `clk_i`.
- `sw_o`  output  WIDTH  debounced, registered switch value.
- `upd_o`  output  1  one-cycle pulse, high in the same cycle `sw_o` takes a new value.
- `busy_o`  output  1  high while a candidate value is settling.

## Operation
- **Synchroniser:** `SYNC_STAGES` flops per bit, all sharing one chain clock. The last stage is the sampled value `s`.
- **Registers:** sync chain, `sw_o`, candidate `cand[WIDTH-1:0]`, counter `cnt` (width `$clog2(DEBOUNCE_CYCLES+1)`), `upd_o`, and the state register.
- **FSM states:** STABLE and SETTLING. `busy_o` = (state == SETTLING), decoded from the state register only.
- **STABLE:**
  - If `s == sw_o`, hold and keep `cnt = 0`.
  - If `s != sw_o`, load `cand <= s` and `cnt <= 1` (first sample), then go to SETTLING.
- **SETTLING** (priority top to bottom):
  - If `s == sw_o` (bounce returned to the old value): go to STABLE with `cnt <= 0`. No update.
  - Else if `s != cand`: load `cand <= s`, `cnt <= 1`, and stay in SETTLING (restart).
  - Else if `cnt == DEBOUNCE_CYCLES-1`: commit with `sw_o <= cand` and `upd_o <= 1`, set `cnt <= 0`, go to STABLE.
  - Else: `cnt <= cnt + 1`.
- `upd_o` is cleared on every edge that does not commit, so it is never high for two consecutive cycles.
- **Bus-level filtering:** any bit change restarts settling for the whole bus. Partial values are never exposed on `sw_o`.
- **Counter width:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`, and there is no wrap-around.

## Timing
- **Reset values** (asserted asynchronously, released synchronously to `clk_i` by the upstream reset source): sync chain = 0, `sw_o` = 0, `cand` = 0, `cnt` = 0, `upd_o` = 0, state = STABLE, `busy_o` = 0.
- **Latency:** if `raw_i` changes and then holds, `sw_o` and `upd_o` update on rising edge number `SYNC_STAGES + DEBOUNCE_CYCLES` after the change. For example, with the defaults and 2/4 settings this is the 6th edge.
- **Busy window:** `busy_o` is high for exactly `DEBOUNCE_CYCLES-1` cycles before the commit edge, and low in the cycle `upd_o` is high.
- **Reset released with switches non-zero:** a normal settle follows, ending in a single `upd_o` pulse.
- **Reset asserted mid-SETTLING:** outputs return to their reset values immediately. No `upd_o` is produced for the aborted candidate.
- **Input changes on the commit edge:** the commit uses the old `s`. The new value arrives through the chain and starts a fresh settle, producing a second `upd_o`.
- **No handshake:** consumers sample `sw_o` continuously, and `upd_o` is informational.

## Test plan
Bench settings: `WIDTH=11`, `SYNC_STAGES=2`, `DEBOUNCE_CYCLES=4`, 10 ns clock.

- **Reset, inputs idle:** reset with `raw_i=0`, release, run 20 cycles → `sw_o=0x000`; `upd_o` and `busy_o` stay 0.
- **Clean change:** step `raw_i` 0x000→0x0A5 and hold → `busy_o` high for 3 cycles; `sw_o=0x0A5` with a single `upd_o` pulse on the 6th edge after the change.
- **Short glitch:** from 0x0A5, drive 0x0A4 for 2 cycles then back to 0x0A5 → `sw_o` stays 0x0A5, no `upd_o`, `busy_o` returns to 0.
- **Bounce then settle:** toggle `raw_i` 0x001/0x002 every 2 cycles for 10 cycles, then hold 0x002 → exactly one `upd_o`, `sw_o=0x002` on the 6th edge after the last toggle, and no intermediate value ever appears.
- **Reset mid-settle:** pull `reset_ni` low on the 2nd cycle of `busy_o` → `sw_o=0`, `busy_o=0`, `upd_o=0` within the same cycle. After release with `raw_i=0x7FF`, `sw_o=0x7FF` six edges later.
- **Change on commit edge:** change `raw_i` 0x010→0x020 on the edge where 0x010 commits → `sw_o=0x010` with `upd_o`, then `sw_o=0x020` with a second `upd_o` six edges after the second change.
